// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs,
// FSM states and ALU operations, plus small decode helpers.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIWB, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    function automatic logic funct_ok(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    function automatic alu_op_t alu_op_of(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // A 5-bit register field is only meaningful if the register exists.
    function automatic logic reg_idx_ok(input logic [4:0] idx, input int nregs);
        return int'({27'b0, idx}) < nregs;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Architectural register file: two combinational read ports, one clocked
// write port, register 0 hardwired to zero, asynchronous clear.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   ra_addr,
    input  logic [AW-1:0]   rb_addr,
    output logic [XLEN-1:0] ra_data,
    output logic [XLEN-1:0] rb_data,
    input  logic            we,
    input  logic [AW-1:0]   w_addr,
    input  logic [XLEN-1:0] w_data
);

    logic [XLEN-1:0] regs [NREGS];

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs[gi] = '0;
            end else begin : g_store
                logic [XLEN-1:0] q_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        q_reg <= '0;
                    end else if (we && (w_addr == AW'(gi))) begin
                        q_reg <= w_data;
                    end
                end
                assign regs[gi] = q_reg;
            end
        end
    endgenerate

    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/mc_core_hs.sv
// Multicycle MIPS-subset core with a req/ready memory port, configurable
// width and register count, halt-on-illegal and retire reporting.
module mc_core_hs
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_ready,
    output logic [XLEN-1:0]  pc,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt,
    output logic             halted
);

    localparam int AW = $clog2(NREGS);

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   pc_reg, a_reg, b_reg, aluout_reg, mdr_reg;
    logic [31:0]       ir_reg;
    logic [CNT_W-1:0]  retire_cnt_reg;

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [XLEN-1:0]   imm_ext, imm_sh2, jump_target, alu_result;
    logic              illegal;

    logic [XLEN-1:0]   rf_ra_data, rf_rb_data, rf_wdata;
    logic [AW-1:0]     rf_waddr;
    logic              rf_we;

    assign op          = ir_reg[31:26];
    assign rs          = ir_reg[25:21];
    assign rt          = ir_reg[20:16];
    assign rd          = ir_reg[15:11];
    assign funct       = ir_reg[5:0];
    assign imm_ext     = {{(XLEN-16){ir_reg[15]}}, ir_reg[15:0]};
    assign imm_sh2     = {imm_ext[XLEN-3:0], 2'b00};
    assign jump_target = {pc_reg[XLEN-1:28], ir_reg[25:0], 2'b00};

    mc_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (rs[AW-1:0]),
        .rb_addr (rt[AW-1:0]),
        .ra_data (rf_ra_data),
        .rb_data (rf_rb_data),
        .we      (rf_we),
        .w_addr  (rf_waddr),
        .w_data  (rf_wdata)
    );

    // Only the fields an opcode actually uses as register numbers are range-checked.
    always_comb begin
        illegal = 1'b0;
        case (op)
            OP_RTYPE: illegal = !funct_ok(funct) || !reg_idx_ok(rs, NREGS) ||
                                !reg_idx_ok(rt, NREGS) || !reg_idx_ok(rd, NREGS);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI:
                      illegal = !reg_idx_ok(rs, NREGS) || !reg_idx_ok(rt, NREGS);
            OP_J:     illegal = 1'b0;
            default:  illegal = 1'b1;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_op_of(funct))
            ALU_ADD: alu_result = a_reg + b_reg;
            ALU_SUB: alu_result = a_reg - b_reg;
            ALU_AND: alu_result = a_reg & b_reg;
            ALU_OR:  alu_result = a_reg | b_reg;
            ALU_SLT: alu_result[0] = $signed(a_reg) < $signed(b_reg);
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus every combinational output: memory port, retire, write-back.
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc_reg;
        mem_wdata  = '0;
        retire     = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = rt[AW-1:0];
        rf_wdata   = aluout_reg;
        case (state_reg)
            RST:    state_next = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                if (illegal) begin
                    state_next = HALT;
                end else begin
                    case (op)
                        OP_LW, OP_SW:      state_next = MEMADR;
                        OP_RTYPE, OP_ADDI: state_next = EXEC;
                        OP_BEQ:            state_next = BRANCH;
                        OP_J:              state_next = JUMP;
                        default:           state_next = HALT;
                    endcase
                end
            end
            MEMADR: state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                mem_req  = 1'b1;
                mem_addr = aluout_reg;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                rf_we      = 1'b1;
                rf_wdata   = mdr_reg;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = aluout_reg;
                mem_wdata = b_reg;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            EXEC:   state_next = (op == OP_ADDI) ? ADDIWB : ALUWB;
            ALUWB: begin
                rf_we      = 1'b1;
                rf_waddr   = rd[AW-1:0];
                retire     = 1'b1;
                state_next = FETCH;
            end
            ADDIWB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            BRANCH, JUMP: begin
                retire     = 1'b1;
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg         <= RESET_PC;
            ir_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            aluout_reg     <= '0;
            mdr_reg        <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (retire) retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            case (state_reg)
                FETCH: begin
                    if (mem_ready) begin
                        ir_reg <= mem_rdata[31:0];
                        pc_reg <= pc_reg + XLEN'(4);
                    end
                end
                DECODE: begin
                    a_reg      <= rf_ra_data;
                    b_reg      <= rf_rb_data;
                    aluout_reg <= pc_reg + imm_sh2;
                end
                MEMADR: aluout_reg <= a_reg + imm_ext;
                MEMRD:  if (mem_ready) mdr_reg <= mem_rdata;
                EXEC:   aluout_reg <= (op == OP_ADDI) ? (a_reg + imm_ext) : alu_result;
                BRANCH: if (a_reg == b_reg) pc_reg <= aluout_reg;
                JUMP:   pc_reg <= jump_target;
                default: ;
            endcase
        end
    end

    assign pc         = pc_reg;
    assign retire_cnt = retire_cnt_reg;
    assign halted     = (state_reg == HALT);

endmodule

// File: tb/tb_mc_core_hs.sv
// Self-checking bench for mc_core_hs: directed programs plus a random
// instruction stream checked against an instruction-level reference model.
module tb_mc_core_hs;

    localparam int XLEN  = 64;
    localparam int NREGS = 8;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mem_req, mem_we, mem_ready, retire, halted;
    logic [XLEN-1:0]  mem_addr, mem_wdata, mem_rdata, pc;
    logic [CNT_W-1:0] retire_cnt;

    always #5 clk = ~clk;

    mc_core_hs #(.XLEN(XLEN), .NREGS(NREGS), .RESET_PC(64'h100), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc),
        .retire     (retire),
        .retire_cnt (retire_cnt),
        .halted     (halted)
    );

    int vectors = 0;
    int miscompares = 0;

    // Environment memory (what the DUT sees) and the model's own data memory.
    logic [63:0] env_mem [logic [63:0]];
    logic [63:0] m_mem   [logic [63:0]];
    logic [63:0] m_reg   [8];
    logic [63:0] m_pc;
    int unsigned m_cnt;

    int          exp_cycles;
    logic        exp_wr;
    logic [63:0] exp_wr_addr, exp_wr_data;

    logic        wr_seen, in_fetch, fetch_pend;
    logic [63:0] wr_addr, wr_data, held_addr, fetch_pc;
    int          req_age;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] env_rd(input logic [63:0] a);
        return env_mem.exists(a) ? env_mem[a] : 64'h0;
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // Architectural effect of one instruction, plus its expected cycle count.
    task automatic model_exec(input logic [31:0] ins, input int stall);
        logic [5:0]  op, fn;
        int          rs, rt, rd, base, acc;
        logic [63:0] a, b, imm, npc, ea;
        op = ins[31:26]; fn = ins[5:0];
        rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
        imm = {{48{ins[15]}}, ins[15:0]};
        a = m_reg[rs]; b = m_reg[rt];
        npc = m_pc + 64'd4; base = 4; acc = 1; exp_wr = 1'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20: m_reg[rd] = a + b;
                    6'h22: m_reg[rd] = a - b;
                    6'h24: m_reg[rd] = a & b;
                    6'h25: m_reg[rd] = a | b;
                    default: m_reg[rd] = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                endcase
            end
            6'h23: begin
                ea = a + imm;
                m_reg[rt] = m_mem.exists(ea) ? m_mem[ea] : 64'h0;
                base = 5; acc = 2;
            end
            6'h2B: begin
                ea = a + imm;
                m_mem[ea] = b;
                exp_wr = 1'b1; exp_wr_addr = ea; exp_wr_data = b; acc = 2;
            end
            6'h04: begin
                base = 3;
                if (a == b) npc = npc + (imm << 2);
            end
            6'h08: m_reg[rt] = a + imm;
            default: begin
                base = 3;
                npc = {npc[63:28], ins[25:0], 2'b00};
            end
        endcase
        m_reg[0] = 64'h0;
        m_pc = npc;
        m_cnt++;
        exp_cycles = base + stall * acc;
    endtask

    // One clock of memory service: each request waits 'stall' cycles before ready.
    task automatic drive_cycle(input int stall, output logic ret);
        @(negedge clk);
        if (fetch_pend) begin
            check("pc_after_fetch", pc, fetch_pc + 64'd4);
            fetch_pend = 1'b0;
        end
        if (mem_req) begin
            if (req_age == 0) begin
                held_addr = mem_addr;
                if (in_fetch) check("fetch_addr", mem_addr, fetch_pc);
            end else begin
                check("addr_stable", mem_addr, held_addr);
            end
            mem_ready = (req_age >= stall);
            mem_rdata = env_rd(mem_addr);
            if (mem_ready) begin
                req_age = 0;
                if (in_fetch) begin
                    in_fetch = 1'b0;
                    fetch_pend = 1'b1;
                end
                if (mem_we) begin
                    wr_seen = 1'b1; wr_addr = mem_addr; wr_data = mem_wdata;
                    env_mem[mem_addr] = mem_wdata;
                end
            end else begin
                req_age++;
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = {$urandom, $urandom};
        end
        #1;
        ret = retire;
    endtask

    task automatic do_instr(input logic [31:0] ins, input int stall);
        int   n;
        logic ret;
        env_mem[m_pc] = {32'h0, ins};
        fetch_pc = m_pc; in_fetch = 1'b1; wr_seen = 1'b0; req_age = 0;
        model_exec(ins, stall);
        n = 0; ret = 1'b0;
        while (!ret && n < 60) begin
            drive_cycle(stall, ret);
            n++;
        end
        check("cycles", 64'(n), 64'(exp_cycles));
        check("mem_write_seen", 64'(wr_seen), 64'(exp_wr));
        if (exp_wr) begin
            check("wr_addr", wr_addr, exp_wr_addr);
            check("wr_data", wr_data, exp_wr_data);
        end
        @(posedge clk); #1;
        check("pc", pc, m_pc);
        check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
        #2;
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", mem_addr, 64'h100);
        check("rst_mem_wdata", mem_wdata, 64'h0);
        check("rst_pc", pc, 64'h100);
        check("rst_retire", 64'(retire), 64'd0);
        check("rst_retire_cnt", 64'(retire_cnt), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("first_cycle_no_req", 64'(mem_req), 64'd0);
        m_pc = 64'h100; m_cnt = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = 64'h0;
        fetch_pend = 1'b0; in_fetch = 1'b0; req_age = 0;
    endtask

    task automatic do_illegal(input logic [31:0] ins, input string tag);
        logic ret;
        env_mem[m_pc] = {32'h0, ins};
        fetch_pc = m_pc; in_fetch = 1'b1; req_age = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(0, ret);
            check({tag, "_retire"}, 64'(ret), 64'd0);
            if (i >= 2) begin
                check({tag, "_halted"}, 64'(halted), 64'd1);
                check({tag, "_req"}, 64'(mem_req), 64'd0);
            end
        end
        check({tag, "_retire_cnt"}, 64'(retire_cnt), 64'(m_cnt));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fns [5];
        int         rs;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        rs = int'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1, 9: return enc_r(rs, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), fns[$urandom_range(0, 4)]);
            2, 3:    return enc_i(6'h08, rs, int'($urandom_range(0, 7)), 16'($urandom));
            4:       return enc_i(6'h23, 0, int'($urandom_range(0, 7)), 16'(16'h4000 + 8 * $urandom_range(0, 31)));
            5:       return enc_i(6'h2B, 0, int'($urandom_range(0, 7)), 16'(16'h4000 + 8 * $urandom_range(0, 31)));
            6, 7:    return enc_i(6'h04, rs, ($urandom_range(0, 1) == 1) ? rs : int'($urandom_range(0, 7)), 16'($urandom_range(0, 3)));
            default: return {6'h02, 26'(((m_pc + 64'd4) >> 2) + 64'($urandom_range(1, 4)))};
        endcase
    endfunction

    initial begin
        logic [63:0] pc_before;
        mem_ready = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 32; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            env_mem[64'h4000 + 64'(8 * i)] = d;
            m_mem[64'h4000 + 64'(8 * i)] = d;
        end
        env_mem[64'h8] = 64'hDEADBEEF;
        m_mem[64'h8] = 64'hDEADBEEF;

        do_reset();

        // addi/addi/add then store the sum, no wait states
        do_instr(enc_i(6'h08, 0, 1, 16'd5), 0);
        do_instr(enc_i(6'h08, 0, 2, 16'hFFFD), 0);
        do_instr(enc_r(1, 2, 3, 6'h20), 0);
        check("retire_cnt_after_3", 64'(retire_cnt), 64'd3);
        do_instr(enc_i(6'h2B, 0, 3, 16'h10), 0);
        check("sum_stored", env_rd(64'h10), 64'd2);

        // stalled load, then store the loaded value
        do_instr(enc_i(6'h23, 0, 4, 16'h8), 3);
        do_instr(enc_i(6'h2B, 0, 4, 16'h18), 2);
        check("lw_value_stored", env_rd(64'h18), 64'hDEADBEEF);
        do_instr(enc_i(6'h2B, 0, 1, 16'h0), 0);

        // branches and jump
        pc_before = m_pc;
        do_instr(enc_i(6'h04, 1, 1, 16'd2), 0);
        check("beq_taken_pc", pc, pc_before + 64'd12);
        pc_before = m_pc;
        do_instr(enc_i(6'h04, 1, 2, 16'd2), 0);
        check("beq_not_taken_pc", pc, pc_before + 64'd4);
        do_instr({6'h02, 26'h40}, 0);
        check("j_target", pc, 64'h100);

        // random program against the reference model
        for (int k = 0; k < 250; k++) begin
            do_instr(rand_instr(), int'($urandom_range(0, 2)));
        end
        for (int r = 1; r < 8; r++) begin
            do_instr(enc_i(6'h2B, 0, r, 16'(16'h5000 + 8 * r)), 0);
        end

        // illegal register index, then illegal opcode; reset must clear the halt
        do_illegal(enc_r(1, 2, 9, 6'h20), "illegal_rd");
        do_reset();
        do_illegal({6'h3F, 26'h0}, "illegal_op");
        do_reset();
        do_instr(enc_i(6'h08, 0, 5, 16'd7), 1);
        do_instr(enc_i(6'h2B, 0, 5, 16'h20), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_core_hs.md
# mc_core_hs

Parametrised multicycle MIPS-subset core: datapath and main-control FSM in one block. It talks to an external single-port memory through a req/ready handshake, so wait states are tolerated. It is the successor to the fixed 32-bit datapath with internal memory. Width, register count and reset vector are configurable, and it adds halt-on-illegal and retire reporting.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- NREGS, 32: number of architectural registers; legal values are 8, 16 and 32.
- RESET_PC, 0: PC value after reset; must be a multiple of 4.
- CNT_W, 32: width of the retire counter.
- clk input 1: the single clock; all state changes on its rising edge.
- rst_n input 1: asynchronous, active-low reset.
- mem_req output 1: memory access request.
- mem_we output 1: 1 = write, 0 = read; valid while mem_req = 1.
- mem_addr output XLEN: byte address.
- mem_wdata output XLEN: write data.
- mem_rdata input XLEN: read data; sampled on the edge where mem_ready = 1.
- mem_ready input 1: access completes on the edge where this is high.
- pc output XLEN: current PC.
- retire output 1: 1-cycle pulse when an instruction completes.
- retire_cnt output CNT_W: count of retired instructions; wraps at 2^CNT_W.
- halted output 1: sticky illegal-instruction flag.

## Operation
- **Supported instructions:**
  - R-type add, sub, and, or, slt (funct 0x20/0x22/0x24/0x25/0x2A).
  - lw 0x23, sw 0x2B, beq 0x04, addi 0x08, j 0x02.
- **Instruction word:** mem_rdata[31:0].
- **Immediate:** sign-extended to XLEN.
- **Jump target:** {pc[XLEN-1:28], instr[25:0], 2'b00}.
- **Register file:**
  - Register 0 reads as 0; writes to it are dropped.
  - Any rs, rt or rd field ≥ NREGS is illegal.
- **FSM states:** RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIWB, JUMP, HALT.
- **State transitions:**
  - RST → FETCH unconditionally.
  - FETCH: on mem_ready, load IR and set pc ← pc+4. Without mem_ready, stay in FETCH.
  - DECODE: latch A and B; ALUOut ← pc + (imm<<2). Then dispatch:
    - lw/sw/addi → MEMADR/MEMADR/EXEC.
    - R-type → EXEC.
    - beq → BRANCH.
    - j → JUMP.
    - illegal opcode, funct or register index → HALT.
  - MEMADR: ALUOut ← A+imm. Then lw → MEMRD, sw → MEMWR.
  - MEMRD: on ready, MDR ← rdata, then → MEMWB. MEMWB: rt ← MDR.
  - MEMWR: on ready, retire.
  - EXEC: ALUOut ← A op B (R-type) or A+imm (addi). Then → ALUWB or ADDIWB.
  - ALUWB: rd ← ALUOut. ADDIWB: rt ← ALUOut.
  - BRANCH: if A==B, pc ← ALUOut; retire.
  - JUMP: pc ← target; retire.
  - After every retiring state, the next state is FETCH.
- **slt:** signed compare; result is 1 or 0, zero-extended.
- **Arithmetic:** add/sub/addi wrap modulo 2^XLEN with no overflow trap.
- **HALT:**
  - Absorbing state; mem_req = 0.
  - halted = 1 until reset.
  - The illegal instruction is not retired.

## Timing
- **Reset values (all asynchronous):**
  - state = RST, pc = RESET_PC, all registers = 0.
  - retire_cnt = 0, halted = 0, retire = 0, mem_req = 0, mem_we = 0.
  - mem_addr = RESET_PC, mem_wdata = 0.
- **Memory outputs:**
  - mem_req, mem_we, mem_addr and mem_wdata are combinational from state and registers.
  - mem_req = 1 only in FETCH, MEMRD and MEMWR.
  - All four are held stable until the mem_ready edge.
  - mem_ready is ignored while mem_req = 0.
- **Cycle counts with mem_ready tied high:** lw 5; sw, R-type and addi 4; beq and j 3.
- **Wait states:** each cycle with mem_ready low adds one cycle to the instruction.
- **retire:**
  - Asserted during the final state's cycle.
  - retire_cnt increments on that same edge.
- **Write-back:** a register written in a write-back state is visible to the next instruction's DECODE.
- **Reset mid-access:** the access is abandoned and no register is written.

## Structure
- **Package mc_pkg:** opcode and funct localparams, state_t enum, alu_op_t enum (ADD, SUB, AND, OR, SLT).
- **Sub-module mc_regfile:** parameters NREGS and XLEN; two asynchronous read ports, one synchronous write port; register 0 hardwired to 0; asynchronous reset clears all registers.
- **mc_core_hs itself:** the FSM, the ALU, the IR/MDR/A/B/ALUOut registers and the muxes.

## Test plan
- **Reset and first fetch:** apply reset with RESET_PC = 0x100, then release it. Required: mem_req = 0 for the first cycle, then a read at 0x100; pc = 0x104 after the ready edge.
- **addi and add, zero-wait:** run addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2. Required: $3 = 2, retire_cnt = 3, at 12 cycles after the first FETCH.
- **Stalled memory:** hold mem_ready low for 3 cycles on both fetch and access of lw $4,8($0) with mem[8] = 0xDEADBEEF. Required: $4 = 0xDEADBEEF, 11 cycles, and mem_addr held stable during each stall.
- **Branches:** beq with equal operands and offset 2 must reach pc+4+8. A not-taken beq must reach pc+4, in 3 cycles.
- **Jump:** j 0x40 with XLEN = 64 must reach pc = {upper bits, 0x100}. sw $1,0($0) must issue a write with mem_wdata = $1.
- **Illegal instruction:** opcode 0x3F, or rd = 9 with NREGS = 8. Required: halted = 1, mem_req stays 0, retire_cnt unchanged, and reset clears the halt.
